// File: rtl/medicine_ack_handler.sv
// medicine_ack_handler
//   Patient-side responder for the medicine reminder. Turns a reminder edge
//   into a buzzer/LED alert, waits for an acknowledge or snooze press, and
//   reports each dose as taken or missed. It also keeps saturating counters
//   for the status display.
//
//   Ports
//     clk, reset          rising-edge clock, synchronous active-high reset
//     medicine_reminder   reminder level; only its rising edge is used
//     ack_btn, snooze_btn raw asynchronous, bouncy buttons
//     buzzer              high in ALERT
//     led_alert           high in ALERT and SNOOZE
//     dose_taken          1-cycle pulse on acknowledge
//     dose_missed         1-cycle pulse on window expiry or overrun
//     taken_count         saturating count of doses taken
//     missed_count        saturating count of doses missed
//     snooze_used         snoozes consumed for the current dose
//     busy                high whenever not IDLE
//
//   Every output is registered from the next-state decode, so each output
//   changes on the same edge as the state it reflects.

// Per-button conditioning: 2-flop synchronizer, then a saturating debounce
// counter. The press pulse is registered, so it fires DEBOUNCE_CYCLES+1 edges
// after the raw level is first sampled high.
module medicine_ack_handler_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      if (!sync_q[1])          cnt_q <= '0;
      else if (cnt_q != DB_MAX) cnt_q <= cnt_q + 1'b1;
      // Fire on the step into DB_MAX; the counter then holds until release.
      press <= sync_q[1] && (cnt_q == DB_MAX - 1'b1);
    end
  end
endmodule

module medicine_ack_handler #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_WINDOW      = 50,
  parameter int SNOOZE_CYCLES   = 20,
  parameter int MAX_SNOOZE      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       medicine_reminder,
  input  logic       ack_btn,
  input  logic       snooze_btn,
  output logic       buzzer,
  output logic       led_alert,
  output logic       dose_taken,
  output logic       dose_missed,
  output logic [7:0] taken_count,
  output logic [7:0] missed_count,
  output logic [1:0] snooze_used,
  output logic       busy
);
  localparam int NUM_LANES = 2;  // lane 0 = ack, lane 1 = snooze
  localparam int WW = $clog2(ACK_WINDOW + 1);
  localparam int SW = $clog2(SNOOZE_CYCLES + 1);
  localparam logic [WW-1:0] WIN_LOAD = WW'(ACK_WINDOW - 1);
  localparam logic [SW-1:0] SNZ_LOAD = SW'(SNOOZE_CYCLES - 1);
  localparam logic [1:0]    MAX_SN   = 2'(MAX_SNOOZE);

  typedef enum logic [2:0] {S_IDLE, S_ALERT, S_SNOOZE, S_TAKEN, S_MISSED} state_t;

  logic [NUM_LANES-1:0] btn_raw, press;
  assign btn_raw = {snooze_btn, ack_btn};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    medicine_ack_handler_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_raw[g]),
      .press (press[g])
    );
  end

  wire ack_press = press[0];
  wire snz_press = press[1];

  // Edge detect is registered so the reminder reaches ALERT one edge after
  // it is first sampled high, matching the registered button presses.
  logic rem_hist_q, rise_q;

  state_t        state_q, state_d;
  logic [WW-1:0] win_q, win_d;
  logic [SW-1:0] snz_q, snz_d;
  logic [1:0]    used_d;
  logic          pend_q, pend_d;
  logic          overrun;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    snz_d   = snz_q;
    used_d  = snooze_used;
    pend_d  = pend_q;
    overrun = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise_q || pend_q) begin
          state_d = S_ALERT;
          win_d   = WIN_LOAD;
          used_d  = '0;
          pend_d  = 1'b0;
        end
      end
      S_ALERT, S_SNOOZE: begin
        if (rise_q) begin
          // A new reminder while the old dose is open: old dose is missed.
          overrun = 1'b1;
          state_d = S_ALERT;
          win_d   = WIN_LOAD;
          used_d  = '0;
        end else if (ack_press) begin
          state_d = S_TAKEN;
        end else if (state_q == S_ALERT) begin
          if (snz_press && (snooze_used < MAX_SN)) begin
            state_d = S_SNOOZE;
            used_d  = snooze_used + 1'b1;
            snz_d   = SNZ_LOAD;
          end else if (win_q == '0) begin
            state_d = S_MISSED;
          end else begin
            win_d = win_q - 1'b1;
          end
        end else begin
          if (snz_q == '0) begin
            state_d = S_ALERT;
            win_d   = WIN_LOAD;
          end else begin
            snz_d = snz_q - 1'b1;
          end
        end
      end
      S_TAKEN, S_MISSED: begin
        state_d = S_IDLE;
        if (rise_q) pend_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_hist_q   <= 1'b0;
      rise_q       <= 1'b0;
      state_q      <= S_IDLE;
      win_q        <= '0;
      snz_q        <= '0;
      pend_q       <= 1'b0;
      snooze_used  <= '0;
      buzzer       <= 1'b0;
      led_alert    <= 1'b0;
      dose_taken   <= 1'b0;
      dose_missed  <= 1'b0;
      busy         <= 1'b0;
      taken_count  <= '0;
      missed_count <= '0;
    end else begin
      rem_hist_q  <= medicine_reminder;
      rise_q      <= medicine_reminder && !rem_hist_q;
      state_q     <= state_d;
      win_q       <= win_d;
      snz_q       <= snz_d;
      pend_q      <= pend_d;
      snooze_used <= used_d;
      buzzer      <= (state_d == S_ALERT);
      led_alert   <= (state_d == S_ALERT) || (state_d == S_SNOOZE);
      dose_taken  <= (state_d == S_TAKEN);
      dose_missed <= (state_d == S_MISSED) || overrun;
      busy        <= (state_d != S_IDLE);
      if ((state_d == S_TAKEN) && (taken_count != 8'hFF))
        taken_count <= taken_count + 1'b1;
      if (((state_d == S_MISSED) || overrun) && (missed_count != 8'hFF))
        missed_count <= missed_count + 1'b1;
    end
  end
endmodule

// File: doc/medicine_ack_handler.md
# medicine_ack_handler

Patient-side responder for the medicine reminder. Consumes the `medicine_reminder` level from the reminder timer and raises a buzzer and LED alert. It then waits for the patient to press acknowledge or snooze, and reports each dose as taken or missed. It sits between the reminder timer and the front-panel I/O, and keeps saturating taken and missed counters for the status display.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-high cycles that count as one button press.
- `ACK_WINDOW`, default 50: cycles the alert stays active before the dose is declared missed.
- `SNOOZE_CYCLES`, default 20: length of one snooze period in cycles.
- `MAX_SNOOZE`, default 2: snoozes allowed per dose.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `medicine_reminder`  in  1  reminder level from the timer; only the rising edge is used.
- `ack_btn`  in  1  raw acknowledge button (asynchronous, bouncy).
- `snooze_btn`  in  1  raw snooze button (asynchronous, bouncy).
- `buzzer`  out  1  high in ALERT.
- `led_alert`  out  1  high in ALERT and SNOOZE.
- `dose_taken`  out  1  one-cycle pulse when a dose is acknowledged.
- `dose_missed`  out  1  one-cycle pulse when a dose is missed or overrun.
- `taken_count`  out  8  doses taken; saturates at 255.
- `missed_count`  out  8  doses missed; saturates at 255.
- `snooze_used`  out  2  snoozes consumed for the current dose.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Input conditioning:**
  - Each button passes through a 2-flop synchronizer, then a debounce counter.
  - The counter increments while the synchronized level is 1 and clears to 0 when the level is 0.
  - An internal press pulse fires for one cycle when the count reaches `DEBOUNCE_CYCLES`.
  - The counter then holds, so there are no further pulses until the button is released.
  - Rising-edge detect on `medicine_reminder` uses a one-flop history register.
- **States:** IDLE, ALERT, SNOOZE, TAKEN, MISSED.
- **IDLE:** a reminder rising edge moves to ALERT, loads window_cnt = `ACK_WINDOW`-1 and clears `snooze_used`. Button presses are ignored.
- **ALERT:** window_cnt decrements by 1 each cycle.
  - Ack press goes to TAKEN.
  - Otherwise, a snooze press with `snooze_used` < `MAX_SNOOZE` goes to SNOOZE, increments `snooze_used` and loads snooze_cnt = `SNOOZE_CYCLES`-1.
  - Otherwise, window_cnt == 0 goes to MISSED.
  - A snooze press with `snooze_used` == `MAX_SNOOZE` is ignored.
- **SNOOZE:** snooze_cnt decrements each cycle.
  - Ack press goes to TAKEN.
  - snooze_cnt == 0 returns to ALERT with a fresh window_cnt = `ACK_WINDOW`-1.
  - Snooze presses are ignored.
- **TAKEN:** one cycle. Pulses `dose_taken`, increments `taken_count` unless it is 255, then goes to IDLE.
- **MISSED:** one cycle. Pulses `dose_missed`, increments `missed_count` unless it is 255, then goes to IDLE.
- **Priority on simultaneous events:** ack > snooze > window expiry.
- **Overrun:** a reminder rising edge while in ALERT or SNOOZE.
  - Goes directly to ALERT with a fresh window and `snooze_used` cleared.
  - Pulses `dose_missed` and increments `missed_count` in that same cycle.
  - A same-cycle ack press is ignored; the overrun wins.
- **Reminder edge while in TAKEN or MISSED:** it is held in a one-bit pending flag and consumed in the following IDLE cycle.

## Timing
- **Reset values:**
  - State IDLE.
  - `buzzer`, `led_alert`, `dose_taken`, `dose_missed` and `busy` = 0.
  - `taken_count`, `missed_count` and `snooze_used` = 0.
  - Synchronizers, debounce counters, edge register and pending flag = 0.
- **Reset mid-operation:** the next cycle is IDLE with all outputs at their reset values, including both counters.
- **Output registration:** all outputs are registered and decoded from the current state, with no combinational path from inputs.
- **Reminder latency:** `medicine_reminder` sampled high at edge N (with history register 0) gives state ALERT, and `buzzer` = 1, after edge N+1.
- **Button latency:** button high from edge B gives the press pulse at edge B+1+`DEBOUNCE_CYCLES`. The state changes at the next edge.
- **Missed-dose timing:** with no presses, ALERT lasts exactly `ACK_WINDOW` cycles, then MISSED lasts 1 cycle. `dose_missed` is high in that single cycle.
- **Snooze timing:** SNOOZE lasts exactly `SNOOZE_CYCLES` cycles, with `buzzer` = 0 and `led_alert` = 1.
- **Back-to-back doses:** the minimum turnaround is one TAKEN or MISSED cycle plus one IDLE cycle.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `ACK_WINDOW`=50, `SNOOZE_CYCLES`=20, `MAX_SNOOZE`=2.
1. **Reset and idle:** hold reset 3 cycles, then release with no stimulus -> all outputs 0 and `busy`=0 for 100 cycles.
2. **Acknowledge:** reminder pulse, then hold ack 10 cycles starting 10 cycles later -> `dose_taken` pulses once and `taken_count`=1. `buzzer` falls before window expiry, `missed_count`=0.
3. **Missed dose:** reminder pulse, no presses -> `buzzer` high for exactly 50 cycles. `dose_missed` is a 1-cycle pulse and `missed_count`=1.
4. **Snooze limit:** three snooze presses, each during ALERT -> `snooze_used` reaches 2 and the third press is ignored. Then no ack -> `missed_count`=1. Total `led_alert` time = 50+20+50+20+50 cycles.
5. **Bounce and overrun:**
   - Ack toggling every 2 cycles -> no press is registered.
   - A second reminder edge during ALERT -> `dose_missed` pulses, the window restarts and `missed_count` increments.
6. **Saturation and reset mid-alert:**
   - 257 acknowledged doses -> `taken_count`=255.
   - Reset asserted in SNOOZE -> IDLE and all counters 0 on the next cycle.
